// File: rtl/gmii_rx_frame_check.sv
// GMII receive frame checker: strips preamble/SFD, forwards frame bytes without the FCS,
// and issues a per-frame CRC/length/PHY verdict with good/bad frame counters.
module gmii_rx_frame_check #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic        e_rxc,
  input  logic        reset_n,
  input  logic        e_rxdv,
  input  logic        e_rxer,
  input  logic [7:0]  e_rxd,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        err_crc,
  output logic        err_len,
  output logic        err_phy,
  output logic [10:0] frame_len,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_END,
    S_DROP
  } state_t;

  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [2:0]  PRE_CNT_MAX = 3'd7;
  localparam logic [10:0] LEN_SAT     = 11'h7FF;
  localparam logic [10:0] FCS_BYTES   = 11'd4;
  localparam logic [10:0] MIN_LEN     = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_LEN     = 11'(MAX_FRAME);

  // Reflected CRC-32, one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_pre_cnt;
  logic [31:0]       r_crc;
  logic [10:0]       r_len;
  logic              r_phy;
  logic [3:0][7:0]   r_dly;

  logic [7:0]        r_out_data;
  logic              r_out_valid;
  logic              r_out_sof;
  logic              r_out_eof;
  logic              r_frame_done;
  logic              r_frame_ok;
  logic              r_err_crc;
  logic              r_err_len;
  logic              r_err_phy;
  logic [10:0]       r_frame_len;
  logic [15:0]       r_good_cnt;
  logic [15:0]       r_bad_cnt;

  logic              w_rx_clean;
  logic              w_pre_start;
  logic              w_pre_inc;
  logic              w_sfd;
  logic              w_data_byte;
  logic              w_end;
  logic              w_fwd;
  logic              w_sof;
  logic              w_err_crc;
  logic              w_err_len;
  logic              w_err_phy;
  logic              w_ok;
  logic [31:0]       w_crc_nxt;

  assign w_rx_clean = e_rxdv && !e_rxer;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge e_rxc or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_WAIT_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_IDLE: begin
        if (!e_rxdv) w_state_nxt = S_IDLE;
      end
      // END behaves as IDLE for the incoming byte so a one-cycle inter-frame gap works.
      S_IDLE, S_END: begin
        w_state_nxt = S_IDLE;
        if (e_rxdv) begin
          w_state_nxt = (w_rx_clean && e_rxd == PRE_BYTE) ? S_PREAMBLE : S_DROP;
        end
      end
      S_PREAMBLE: begin
        if (!e_rxdv) begin
          w_state_nxt = S_IDLE;
        end else if (e_rxer) begin
          w_state_nxt = S_DROP;
        end else if (e_rxd == SFD_BYTE) begin
          w_state_nxt = S_DATA;
        end else if (e_rxd == PRE_BYTE && r_pre_cnt != PRE_CNT_MAX) begin
          w_state_nxt = S_PREAMBLE;
        end else begin
          w_state_nxt = S_DROP;
        end
      end
      S_DATA: begin
        if (!e_rxdv) w_state_nxt = S_END;
      end
      S_DROP: begin
        if (!e_rxdv) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_WAIT_IDLE;
    endcase
  end

  always_comb begin
    w_pre_start = 1'b0;
    w_pre_inc   = 1'b0;
    w_sfd       = 1'b0;
    w_data_byte = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      S_IDLE, S_END: begin
        w_pre_start = w_rx_clean && (e_rxd == PRE_BYTE);
      end
      S_PREAMBLE: begin
        w_sfd     = w_rx_clean && (e_rxd == SFD_BYTE);
        w_pre_inc = w_rx_clean && (e_rxd == PRE_BYTE) && (r_pre_cnt != PRE_CNT_MAX);
      end
      S_DATA: begin
        w_data_byte = e_rxdv;
        w_end       = !e_rxdv;
      end
      default: ;
    endcase
  end

  // Byte k leaves the delay line when byte k+4 arrives, so the FCS is never forwarded.
  assign w_fwd     = w_data_byte && (r_len >= FCS_BYTES);
  assign w_sof     = w_data_byte && (r_len == FCS_BYTES);
  assign w_crc_nxt = crc32_byte(r_crc, e_rxd);

  assign w_err_crc = (r_crc != CRC_RESIDUE);
  assign w_err_len = (r_len < MIN_LEN) || (r_len > MAX_LEN);
  assign w_err_phy = r_phy;
  assign w_ok      = !(w_err_crc || w_err_len || w_err_phy);

  // NOTE: the delay line is reset along with the datapath; it is four flops, not a RAM,
  // so clearing it is cheap and keeps out_data deterministic after reset.
  always_ff @(posedge e_rxc or negedge reset_n) begin
    if (!reset_n) begin
      r_pre_cnt <= '0;
      r_crc     <= '0;
      r_len     <= '0;
      r_phy     <= 1'b0;
      r_dly     <= '0;
    end else begin
      if (w_pre_start) begin
        r_pre_cnt <= 3'd1;
      end else if (w_pre_inc) begin
        r_pre_cnt <= r_pre_cnt + 3'd1;
      end
      if (w_sfd) begin
        r_crc <= CRC_INIT;
        r_len <= '0;
        r_phy <= 1'b0;
      end else if (w_data_byte) begin
        r_crc <= w_crc_nxt;
        r_dly <= {r_dly[2:0], e_rxd};
        if (r_len != LEN_SAT) r_len <= r_len + 11'd1;
        if (e_rxer) r_phy <= 1'b1;
      end
    end
  end

  always_ff @(posedge e_rxc or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_sof    <= 1'b0;
      r_out_eof    <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_crc    <= 1'b0;
      r_err_len    <= 1'b0;
      r_err_phy    <= 1'b0;
      r_frame_ok   <= 1'b0;
      r_frame_len  <= '0;
      r_good_cnt   <= '0;
      r_bad_cnt    <= '0;
    end else begin
      r_out_valid  <= w_fwd;
      r_out_sof    <= w_sof;
      r_out_eof    <= w_end;
      r_frame_done <= w_end;
      r_err_crc    <= w_end && w_err_crc;
      r_err_len    <= w_end && w_err_len;
      r_err_phy    <= w_end && w_err_phy;
      if (w_fwd) r_out_data <= r_dly[3];
      if (w_end) begin
        r_frame_ok  <= w_ok;
        r_frame_len <= r_len;
        if (w_ok) begin
          r_good_cnt <= r_good_cnt + 16'd1;
        end else begin
          r_bad_cnt <= r_bad_cnt + 16'd1;
        end
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign out_sof    = r_out_sof;
  assign out_eof    = r_out_eof;
  assign frame_done = r_frame_done;
  assign frame_ok   = r_frame_ok;
  assign err_crc    = r_err_crc;
  assign err_len    = r_err_len;
  assign err_phy    = r_err_phy;
  assign frame_len  = r_frame_len;
  assign good_cnt   = r_good_cnt;
  assign bad_cnt    = r_bad_cnt;

endmodule

// File: doc/gmii_rx_frame_check.md
Name: gmii_rx_frame_check

Overview:
Receive-side GMII frame checker between the RGMII-to-GMII converter and the UDP receiver, in the e_rxc domain. It strips preamble and SFD, forwards frame bytes with FCS removed, and checks CRC-32, frame length and PHY errors. It reports a per-frame verdict and keeps good/bad frame counters, so the UDP receiver only commits RAM writes for frames with frame_ok.

Parameters:
MIN_FRAME, 64, minimum legal frame length in bytes after SFD, FCS included
MAX_FRAME, 1518, maximum legal frame length in bytes after SFD, FCS included

Ports:
e_rxc  in  1  GMII receive clock, 125 MHz
reset_n  in  1  asynchronous active-low reset
e_rxdv  in  1  GMII receive data valid
e_rxer  in  1  GMII receive error
e_rxd  in  8  GMII receive data
out_data  out  8  frame byte, FCS excluded
out_valid  out  1  out_data valid
out_sof  out  1  first out_data byte of frame (with out_valid)
out_eof  out  1  end-of-frame marker; single cycle; out_valid=0 on that cycle
frame_done  out  1  verdict strobe; same cycle as out_eof
frame_ok  out  1  frame passed all checks; meaningful with frame_done
err_crc  out  1  FCS mismatch; meaningful with frame_done
err_len  out  1  length outside [MIN_FRAME, MAX_FRAME]; meaningful with frame_done
err_phy  out  1  e_rxer seen after SFD; meaningful with frame_done
frame_len  out  11  bytes after SFD, FCS included, saturating at 2047; held until next frame_done
good_cnt  out  16  count of frame_ok frames, wraps
bad_cnt  out  16  count of completed frames with any error, wraps

Behaviour:
- Reset (async, reset_n low) clears all outputs, counters, the CRC register and the delay line to 0, and puts the FSM in WAIT_IDLE. Inputs are sampled on the rising edge of e_rxc.
- FSM states and transitions:
  - WAIT_IDLE: go to IDLE when e_rxdv=0. Prevents mid-frame pickup after reset.
  - IDLE:
    - e_rxdv=1, e_rxd=0x55, e_rxer=0 -> PREAMBLE (preamble count=1).
    - e_rxdv=1 with any other byte, or with e_rxer=1 -> DROP.
  - PREAMBLE:
    - 0x55 -> stay; preamble count increments, saturating at 7.
    - 0xD5 -> DATA; CRC register = 0xFFFFFFFF, len=0.
    - A count above 7 before SFD, any other byte, or e_rxer=1 -> DROP.
    - e_rxdv falling -> IDLE.
    - No frame_done is issued for frames that end in PREAMBLE.
  - DATA:
    - Each byte with e_rxdv=1 updates the CRC (reflected, poly 0xEDB88320, LSB first), increments len (saturating at 2047), and shifts into a 4-byte delay line.
    - e_rxer=1 sets a sticky phy flag.
    - e_rxdv=0 -> END.
  - END (1 cycle):
    - out_eof=1 and frame_done=1.
    - err_crc = (CRC register != 0xDEBB20E3).
    - err_len = (len < MIN_FRAME or len > MAX_FRAME).
    - err_phy = sticky phy flag.
    - frame_ok = no error.
    - frame_len = len.
    - good_cnt or bad_cnt increments.
    - Next state: IDLE.
  - DROP: go to IDLE when e_rxdv=0. No outputs, no counters.
- Forwarding:
  - Byte k after SFD is driven on out_data with out_valid=1 on the cycle after the edge that samples byte k+4.
  - The last 4 bytes (FCS) are never forwarded.
  - out_sof accompanies k=0.
  - Frames with len<=4 forward nothing but still produce END (err_len, err_crc set).
- Registered outputs: out_valid, out_sof, out_eof, frame_done and the error bits are pulses of exactly one cycle. frame_len and frame_ok hold until the next frame_done.
- Back-to-back frames: dv low for a single cycle is legal. The END cycle coincides with that idle cycle, and the next preamble byte is accepted in IDLE on the following cycle.
- Counters wrap from 0xFFFF to 0x0000.
- Reset asserted mid-frame aborts immediately with no frame_done. After release the FSM waits in WAIT_IDLE until e_rxdv=0.

Test Plan:
- 7x0x55, 0xD5, 60 payload bytes 0x00..0x3B, bench-computed FCS -> 60 out_valid bytes 0x00..0x3B, out_sof on 0x00, frame_done with frame_ok=1, frame_len=64, good_cnt=1.
- Same frame with payload byte 10 bit-flipped -> err_crc=1, frame_ok=0, bad_cnt=1, 60 bytes still forwarded.
- 40-byte frame with valid FCS -> err_len=1, err_crc=0, frame_len=40; 1600-byte valid frame -> err_len=1, frame_len=1600.
- e_rxer pulsed for one cycle at payload byte 20 of a valid 64-byte frame -> err_phy=1, frame_ok=0; e_rxer in preamble -> DROP, no frame_done, counters unchanged.
- Bad SFD 0xD4 after preamble -> no out_valid, no frame_done; two valid frames separated by 1 idle cycle -> two frame_done, good_cnt=2.
- reset_n low at payload byte 30, released while dv=1 -> no output until dv drops; next valid frame has frame_ok=1, good_cnt=1.
